// File: rtl/di_bus_arbiter.sv
// Round-robin arbiter sharing the device-interface register bus between host and local requesters.
// Optional slave-ready timeout is built when DI_ARB_TIMEOUT_EN is defined.

// state | meaning
// IDLE  | bus free; grant host or local on request (round-robin on tie)
// XFER  | strobe held on bus until slave ready (or timeout)
// ACK   | one-cycle ack/err/rdata to the owner; requests ignored
module di_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] ERR_RDATA      = 16'hDEAD
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [15:0] h_ep,
  input  logic [15:0] h_addr,
  input  logic [15:0] h_wdata,
  output logic        h_ack,
  output logic        h_err,
  output logic [15:0] h_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [15:0] l_ep,
  input  logic [15:0] l_addr,
  input  logic [15:0] l_wdata,
  output logic        l_ack,
  output logic        l_err,
  output logic [15:0] l_rdata,
  output logic [15:0] diEpAddr,
  output logic [15:0] diRegAddr,
  output logic [15:0] diRegDataIn,
  output logic        diWrite,
  output logic        diRead,
  input  logic [15:0] diRegDataOut,
  input  logic        wr_ready,
  input  logic        rd_ready,
  output logic        busy,
  output logic        gnt_local
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ep_nxt, addr_nxt, wdata_nxt;
  logic        wr_nxt, rd_nxt;
  logic        gnt_nxt;
  logic        last_local, last_nxt;
  logic        h_ack_nxt, l_ack_nxt;
  logic [15:0] h_rdata_nxt, l_rdata_nxt;
  logic        busy_nxt;
  logic        pick_local;
  logic        xfer_done;

`ifdef DI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt, to_cnt_nxt;
  logic        h_err_nxt, l_err_nxt;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = {ERR_RDATA, 16'(TIMEOUT_CYCLES)};
  assign h_err = 1'b0;
  assign l_err = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    ep_nxt      = diEpAddr;
    addr_nxt    = diRegAddr;
    wdata_nxt   = diRegDataIn;
    wr_nxt      = diWrite;
    rd_nxt      = diRead;
    gnt_nxt     = gnt_local;
    last_nxt    = last_local;
    h_ack_nxt   = 1'b0;
    l_ack_nxt   = 1'b0;
    h_rdata_nxt = h_rdata;
    l_rdata_nxt = l_rdata;
    pick_local  = 1'b0;
    xfer_done   = 1'b0;
`ifdef DI_ARB_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
    h_err_nxt   = h_err;
    l_err_nxt   = l_err;
`endif

    case (state)
      ST_IDLE: begin
        if (h_req || l_req) begin
          // on a tie the requester that did not own the last transaction wins
          pick_local = h_req ? (l_req && !last_local) : 1'b1;
          gnt_nxt    = pick_local;
          ep_nxt     = pick_local ? l_ep    : h_ep;
          addr_nxt   = pick_local ? l_addr  : h_addr;
          wdata_nxt  = pick_local ? l_wdata : h_wdata;
          wr_nxt     = pick_local ? l_we    : h_we;
          rd_nxt     = pick_local ? !l_we   : !h_we;
          state_nxt  = ST_XFER;
`ifdef DI_ARB_TIMEOUT_EN
          to_cnt_nxt = 16'd0;
`endif
        end
      end

      ST_XFER: begin
        xfer_done = (diWrite && wr_ready) || (diRead && rd_ready);
        if (xfer_done) begin
          wr_nxt    = 1'b0;
          rd_nxt    = 1'b0;
          state_nxt = ST_ACK;
          if (gnt_local) begin
            l_ack_nxt = 1'b1;
            if (diRead) l_rdata_nxt = diRegDataOut;
          end else begin
            h_ack_nxt = 1'b1;
            if (diRead) h_rdata_nxt = diRegDataOut;
          end
`ifdef DI_ARB_TIMEOUT_EN
          if (gnt_local) l_err_nxt = 1'b0;
          else           h_err_nxt = 1'b0;
        end else if (to_cnt == TO_LAST) begin
          // counter reaching the limit means this was the last permitted XFER cycle
          wr_nxt    = 1'b0;
          rd_nxt    = 1'b0;
          state_nxt = ST_ACK;
          if (gnt_local) begin
            l_ack_nxt   = 1'b1;
            l_err_nxt   = 1'b1;
            l_rdata_nxt = ERR_RDATA;
          end else begin
            h_ack_nxt   = 1'b1;
            h_err_nxt   = 1'b1;
            h_rdata_nxt = ERR_RDATA;
          end
        end else begin
          to_cnt_nxt = to_cnt + 16'd1;
`endif
        end
      end

      ST_ACK: begin
        last_nxt  = gnt_local;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      diEpAddr    <= 16'd0;
      diRegAddr   <= 16'd0;
      diRegDataIn <= 16'd0;
      diWrite     <= 1'b0;
      diRead      <= 1'b0;
      gnt_local   <= 1'b0;
      last_local  <= 1'b1;
      h_ack       <= 1'b0;
      l_ack       <= 1'b0;
      h_rdata     <= 16'd0;
      l_rdata     <= 16'd0;
      busy        <= 1'b0;
`ifdef DI_ARB_TIMEOUT_EN
      to_cnt      <= 16'd0;
      h_err       <= 1'b0;
      l_err       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      diEpAddr    <= ep_nxt;
      diRegAddr   <= addr_nxt;
      diRegDataIn <= wdata_nxt;
      diWrite     <= wr_nxt;
      diRead      <= rd_nxt;
      gnt_local   <= gnt_nxt;
      last_local  <= last_nxt;
      h_ack       <= h_ack_nxt;
      l_ack       <= l_ack_nxt;
      h_rdata     <= h_rdata_nxt;
      l_rdata     <= l_rdata_nxt;
      busy        <= busy_nxt;
`ifdef DI_ARB_TIMEOUT_EN
      to_cnt      <= to_cnt_nxt;
      h_err       <= h_err_nxt;
      l_err       <= l_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_di_bus_arbiter.sv
// Self-checking bench for di_bus_arbiter: transaction-level model compared every cycle
// plus directed scenarios with literal expectations.
module tb_di_bus_arbiter;

  localparam int          TO   = 8;
  localparam logic [15:0] ERRD = 16'hDEAD;
`ifdef DI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        if_clock = 1'b0;
  logic        resetb;
  logic        h_req = 0, h_we = 0, l_req = 0, l_we = 0;
  logic [15:0] h_ep = 0, h_addr = 0, h_wdata = 0, l_ep = 0, l_addr = 0, l_wdata = 0;
  logic        h_ack, h_err, l_ack, l_err;
  logic [15:0] h_rdata, l_rdata;
  logic [15:0] diEpAddr, diRegAddr, diRegDataIn;
  logic        diWrite, diRead;
  logic [15:0] diRegDataOut = 0;
  logic        wr_ready = 0, rd_ready = 0;
  logic        busy, gnt_local;

  int n_vec = 0;
  int n_err = 0;

  always #5 if_clock = ~if_clock;

  di_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)) dut (
    .if_clock(if_clock), .resetb(resetb),
    .h_req(h_req), .h_we(h_we), .h_ep(h_ep), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_err(h_err), .h_rdata(h_rdata),
    .l_req(l_req), .l_we(l_we), .l_ep(l_ep), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_err(l_err), .l_rdata(l_rdata),
    .diEpAddr(diEpAddr), .diRegAddr(diRegAddr), .diRegDataIn(diRegDataIn),
    .diWrite(diWrite), .diRead(diRead), .diRegDataOut(diRegDataOut),
    .wr_ready(wr_ready), .rd_ready(rd_ready), .busy(busy), .gnt_local(gnt_local)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a transaction is granted at age 0, completes at the edge
  // recorded in m_end (ready or timeout), acks for one cycle, then frees the bus.
  bit          m_active = 0, m_owner = 0, m_we = 0, m_last = 1, m_gnt = 0;
  int          m_age = 0, m_end = -1;
  logic [15:0] m_ep = 0, m_addr = 0, m_wdata = 0, m_hr = 0, m_lr = 0;
  bit          m_he = 0, m_le = 0;

  always @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      m_active <= 0; m_owner <= 0; m_we <= 0; m_last <= 1; m_gnt <= 0;
      m_age <= 0; m_end <= -1;
      m_ep <= 0; m_addr <= 0; m_wdata <= 0; m_hr <= 0; m_lr <= 0; m_he <= 0; m_le <= 0;
    end else if (!m_active) begin
      if (h_req || l_req) begin
        automatic bit win = (h_req && l_req) ? !m_last : l_req;
        m_active <= 1; m_owner <= win; m_gnt <= win; m_age <= 0; m_end <= -1;
        m_we     <= win ? l_we    : h_we;
        m_ep     <= win ? l_ep    : h_ep;
        m_addr   <= win ? l_addr  : h_addr;
        m_wdata  <= win ? l_wdata : h_wdata;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_end >= 0) begin
        m_active <= 0;
        m_last   <= m_owner;
      end else if ((m_we && wr_ready) || (!m_we && rd_ready)) begin
        m_end <= m_age + 1;
        if (m_owner) begin m_le <= 0; if (!m_we) m_lr <= diRegDataOut; end
        else         begin m_he <= 0; if (!m_we) m_hr <= diRegDataOut; end
      end else if (TO_EN && (m_age + 1 == TO)) begin
        m_end <= m_age + 1;
        if (m_owner) begin m_le <= 1; m_lr <= ERRD; end
        else         begin m_he <= 1; m_hr <= ERRD; end
      end
    end
  end

  always @(negedge if_clock) begin
    automatic bit strobe = m_active && (m_end < 0);
    automatic bit ack    = m_active && (m_end >= 0);
    automatic logic [87:0] exp_v = {strobe && m_we, strobe && !m_we, m_active, m_gnt,
                                    ack && !m_owner, ack && m_owner, m_he, m_le,
                                    m_ep, m_addr, m_wdata, m_hr, m_lr};
    automatic logic [87:0] act_v = {diWrite, diRead, busy, gnt_local, h_ack, l_ack, h_err, l_err,
                                    diEpAddr, diRegAddr, diRegDataIn, h_rdata, l_rdata};
    chk("cycle_model", 96'(act_v), 96'(exp_v));
  end

  task automatic wait_strobe(input int maxc);
    int k = 0;
    @(negedge if_clock);
    while (!(diWrite || diRead) && k < maxc) begin
      @(negedge if_clock);
      k++;
    end
    if (!(diWrite || diRead)) chk("strobe_wait", 0, 1);
  endtask

  task automatic wait_ack(input int maxc);
    int k = 0;
    @(negedge if_clock);
    while (!(h_ack || l_ack) && k < maxc) begin
      @(negedge if_clock);
      k++;
    end
    if (!(h_ack || l_ack)) chk("ack_wait", 0, 1);
  endtask

  task automatic host_write(input logic [15:0] ep, input logic [15:0] addr, input logic [15:0] wd);
    h_req = 1; h_we = 1; h_ep = ep; h_addr = addr; h_wdata = wd; wr_ready = 1;
    wait_strobe(10);
    chk("hw_bus", {diWrite, diEpAddr, diRegAddr, diRegDataIn}, {1'b1, ep, addr, wd});
    @(negedge if_clock);
    chk("hw_strobe_1cyc_ack", {diWrite, h_ack, h_err, l_ack}, 4'b0100);
    h_req = 0; wr_ready = 0;
    @(negedge if_clock);
  endtask

  initial begin
    int len;
    bit saw_ack;
    resetb = 0;
    repeat (2) @(negedge if_clock);
    chk("reset_outs", {busy, diWrite, diRead, gnt_local, h_ack, l_ack, h_err, l_err, diEpAddr, h_rdata},
        42'd0);
    resetb = 1;
    @(negedge if_clock);

    host_write(16'h0003, 16'h0010, 16'h1234);

    // local read, ready in the 6th strobe cycle
    l_req = 1; l_we = 0; l_ep = 16'h0001; l_addr = 16'h0020; diRegDataOut = 16'hBEEF;
    wait_strobe(10);
    len = 1;
    repeat (5) begin @(negedge if_clock); if (diRead) len++; end
    rd_ready = 1;
    @(negedge if_clock);
    chk("lr_strobe_len", len, 6);
    chk("lr_ack", {diRead, l_ack, h_ack, l_err, l_rdata}, {4'b0100, 16'hBEEF});
    l_req = 0; rd_ready = 0;
    @(negedge if_clock);

`ifdef DI_ARB_TIMEOUT_EN
    h_req = 1; h_we = 0; h_addr = 16'h0044; diRegDataOut = 16'h1111;
    wait_strobe(10);
    len = 1;
    while (diRead && len < 50) begin @(negedge if_clock); if (diRead) len++; end
    chk("to_strobe_len", len, TO);
    chk("to_ack", {h_ack, h_err, h_rdata}, {2'b11, 16'hDEAD});
    h_req = 0;
    @(negedge if_clock);
    h_req = 1; diRegDataOut = 16'h5555;
    wait_strobe(10);
    len = 1;
    repeat (7) begin @(negedge if_clock); if (diRead) len++; end
    rd_ready = 1;
    @(negedge if_clock);
    chk("to_edge_len", len, 8);
    chk("to_edge_ack", {h_ack, h_err, h_rdata}, {2'b10, 16'h5555});
    h_req = 0; rd_ready = 0;
    @(negedge if_clock);
`else
    l_req = 1; l_we = 0; l_addr = 16'h0030; diRegDataOut = 16'h2222;
    wait_strobe(10);
    saw_ack = 0;
    repeat (2000) begin @(negedge if_clock); if (h_ack || l_ack) saw_ack = 1; end
    chk("noto_hold", {diRead, saw_ack}, 2'b10);
    diRegDataOut = 16'h0F0F; rd_ready = 1;
    @(negedge if_clock);
    chk("noto_done", {l_ack, l_err, l_rdata}, {2'b10, 16'h0F0F});
    l_req = 0; rd_ready = 0;
    @(negedge if_clock);
`endif

    // make the host the last owner so a surviving pointer would favour local
    host_write(16'h0007, 16'h0070, 16'h7777);

    l_req = 1; l_we = 1; l_ep = 16'h00B0; l_addr = 16'h00B1; l_wdata = 16'h00B2; wr_ready = 0;
    wait_strobe(10);
    #2 resetb = 0;
    #1 chk("reset_mid_xfer", {diWrite, busy, h_ack, l_ack}, 4'b0000);
    h_req = 1; h_we = 1; h_ep = 16'h00A0; h_addr = 16'h00A1; h_wdata = 16'h00A2; wr_ready = 1;
    @(negedge if_clock);
    resetb = 1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(10);
      chk("rr_gnt", {gnt_local, h_ack, l_ack}, (i % 2 == 0) ? 3'b010 : 3'b101);
    end
    h_req = 0; l_req = 0; wr_ready = 0;
    repeat (4) @(negedge if_clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/di_bus_arbiter.md
# di_bus_arbiter

Two-port arbiter that shares the single device-interface register bus (`diEpAddr`/`diRegAddr`/`diRegDataIn`/`diWrite`/`diRead`) between the host-side requester (the PC command path) and a local on-chip requester (e.g. a sequencer or self-test engine). It sits between the host command decoder and the endpoint register slaves. It serialises one transaction at a time, uses round-robin priority on contention, and returns read data and completion or error status to the winning requester.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum cycles the block waits for slave ready before aborting. Legal range 1..65535. Used only with `DI_ARB_TIMEOUT_EN`.
- `ERR_RDATA`, default 16'hDEAD: read data returned on an aborted transaction.

Ports:
- `if_clock`  in  1  sole clock; all logic on its rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `h_req`  in  1  host request, level; held until `h_ack`.
- `h_we`  in  1  host op: 1 = write, 0 = read; stable while `h_req`.
- `h_ep`, `h_addr`, `h_wdata`  in  16 each  host endpoint, register address and write data; stable while `h_req`.
- `h_ack`  out  1  one-cycle completion pulse to host.
- `h_err`  out  1  valid with `h_ack`; 1 = timeout abort.
- `h_rdata`  out  16  read data; valid with `h_ack`, holds until the next host ack.
- `l_req`, `l_we`, `l_ep`, `l_addr`, `l_wdata`, `l_ack`, `l_err`, `l_rdata`: the same signals for the local requester.
- `diEpAddr`, `diRegAddr`, `diRegDataIn`  out  16 each  registered bus address and data.
- `diWrite`, `diRead`  out  1  bus strobes, held until ready.
- `diRegDataOut`  in  16  slave read data.
- `wr_ready`, `rd_ready`  in  1  slave completion for write and read.
- `busy`  out  1  high in any state other than IDLE.
- `gnt_local`  out  1  owner of the current or last transaction: 0 = host, 1 = local.

## Operation

The FSM has three states: IDLE, XFER and ACK.

- **IDLE**
  - If no requester is active, the block stays in IDLE.
  - If exactly one requester is active, that requester is granted.
  - If both are active, the requester that was not granted last wins.
  - On grant, latch the winner's ep, addr and wdata onto `di*`, set `gnt_local`, load the strobe (`diWrite` = we, `diRead` = !we), clear the timeout counter, and go to XFER.
- **XFER**
  - The strobe stays high with the bus values stable.
  - Completion is the cycle where `diWrite && wr_ready` or `diRead && rd_ready` is sampled high.
  - On completion: drop the strobe, capture `diRegDataOut` for a read, clear err, and go to ACK.
  - A write leaves the owner's rdata unchanged.
- **ACK**
  - Pulse the owner's ack for one cycle with err and rdata valid.
  - Update the round-robin pointer to the owner.
  - Go to IDLE unconditionally; requests are ignored in this state.
- Requester rule: deassert req in the cycle after sampling ack. A req still high in IDLE after ACK starts a new transaction.
- `h_*` and `l_*` inputs are not sampled outside the IDLE grant cycle.
- Reset values: state IDLE; every output 0 (all `di*`, strobes, acks, errs, rdata, `busy`, `gnt_local`).
  - The round-robin pointer resets to "local granted last", so the host wins the first tie.
- Reset asserted mid-XFER clears the strobes asynchronously. No ack is issued for the aborted transaction.

## Timing

- Grant latency: req sampled in IDLE at edge n puts the strobe high in cycle n+1.
- Minimum transaction is 3 cycles: IDLE→XFER, ready in the first XFER cycle, then ACK. This gives ack 2 cycles after the grant edge.
- Ready that is already high when the strobe rises completes in the first XFER cycle.
- Ready is ignored while no strobe is asserted.
- Back-to-back throughput is one transaction per 3 cycles plus slave wait cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `DI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter increments each XFER cycle.
  - If ready has not arrived when the counter reaches `TIMEOUT_CYCLES`, drop the strobe, set err = 1, set rdata = `ERR_RDATA` (for reads and writes), and go to ACK.
  - Ready arriving in the same cycle as the timeout wins: it completes normally with err = 0.
- `DI_ARB_TIMEOUT_EN` undefined:
  - No counter is built; XFER waits indefinitely.
  - `h_err` and `l_err` are tied to 0.

## Test plan

- **Host write:** `h_req`=1, `h_we`=1, ep=0x0003, addr=0x0010, wdata=0x1234, `wr_ready` held 1 → `diWrite` high exactly 1 cycle with `di*`=0x0003/0x0010/0x1234; `h_ack` 2 cycles after the grant edge; `h_err`=0.
- **Local read with wait states:** `l_req` read, addr=0x0020, `rd_ready` rises 5 cycles after `diRead`, `diRegDataOut`=0xBEEF → `diRead` high for 6 cycles; `l_ack` pulse with `l_rdata`=0xBEEF; `h_ack` stays 0.
- **Contention:** both req high from reset, each re-requesting after every ack → grants alternate host, local, host, local; `gnt_local` = 0,1,0,1.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=8): read with `rd_ready` never high → strobe drops after 8 XFER cycles; `h_ack`=1, `h_err`=1, `h_rdata`=0xDEAD. Repeat with `rd_ready` arriving on cycle 8 → err=0.
- **Reset mid-XFER:** `resetb` low while `diWrite`=1 → `diWrite`, `busy`, acks go 0 immediately. After release, the next tie is granted to the host.
- **No timeout** (macro off): `rd_ready` held low for 2000 cycles → `diRead` stays high and no ack fires; ready then completes normally with err=0.
